// File: rtl/stream_sink_fifo_if.sv
// Sample stream bundle: push-only input side plus valid/ready output side.
// The FIFO takes the slave modport; the producer/consumer pair takes master.
interface stream_sink_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_vld;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_vld;
    logic                  data_out_rdy;

    modport master (
        output data_in,
        output data_in_vld,
        input  data_out,
        input  data_out_vld,
        output data_out_rdy
    );

    modport slave (
        input  data_in,
        input  data_in_vld,
        output data_out,
        output data_out_vld,
        input  data_out_rdy
    );
endinterface

// File: rtl/stream_sink_fifo.sv
// First-word-fall-through sink FIFO; a sample is visible one cycle after its write edge.
// Input cannot be stalled: when full without a same-cycle read, samples are dropped and counted.
module stream_sink_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_sink_fifo_if.slave     sif,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    input  logic                  ovf_clr
);
    localparam logic [ADDR_WIDTH:0]  PTR_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   fill_level_q, fill_level_d;
    logic                  data_out_vld_q, data_out_vld_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

    logic full;
    logic rd_en;
    logic wr_en;
    logic drop;

    always_comb begin
        full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        rd_en = data_out_vld_q && sif.data_out_rdy;
        // A read in the same cycle frees the head slot, so a full FIFO can still accept.
        wr_en = sif.data_in_vld && (!full || rd_en);
        drop  = sif.data_in_vld && full && !rd_en;

        wr_ptr_d       = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d       = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        fill_level_d   = wr_ptr_d - rd_ptr_d;
        data_out_vld_d = (wr_ptr_d != rd_ptr_d);

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = CNT_ONE;
            end else if (!(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + CNT_ONE;
            end
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_level_q   <= '0;
            data_out_vld_q <= 1'b0;
            overflow_q     <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_level_q   <= fill_level_d;
            data_out_vld_q <= data_out_vld_d;
            overflow_q     <= overflow_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // Storage carries no reset; the sample arriving during reset must not land.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= sif.data_in;
        end
    end

    always_comb begin
        sif.data_out     = data_out_vld_q ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : '0;
        sif.data_out_vld = data_out_vld_q;
        fill_level       = fill_level_q;
        overflow         = overflow_q;
        drop_cnt         = drop_cnt_q;
    end
endmodule
